// File: rtl/expr_stream_arb.sv
// expr_stream_arb: round-robin arbiter sharing one single-digit expression
// checker (grammar: digit (op digit)*) between N character streams.
// One verdict per TERM-terminated frame.
// Optional feature macro: EXPR_TIMEOUT_EN (abort a stalled frame after TIMEOUT cycles).
module expr_stream_arb #(
  parameter int unsigned N       = 2,
  parameter int unsigned ID_W    = 1,
  parameter logic [7:0]  TERM    = 8'd59,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [N-1:0]    req_valid,
  input  logic [8*N-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            res_valid,
  output logic            res_ok,
  output logic [ID_W-1:0] res_id
);

  // One counter width covers both the saturating frame length and the stall count
  localparam int unsigned CNT_MAX = (MAX_LEN + 1 > TIMEOUT) ? MAX_LEN + 1 : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REPORT} state_t;
  typedef enum logic [1:0] {CHK_START, CHK_NUM, CHK_OP} chk_t;

  state_t            state;
  chk_t              chk_st;
  logic              bad;
  logic [CNT_W-1:0]  len;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
`ifdef EXPR_TIMEOUT_EN
  logic [CNT_W-1:0]  stall;
`endif

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  int unsigned       cand;
  logic [7:0]        cur_data;
  logic              cur_valid;
  logic              is_digit;
  logic              is_term;

  assign req_ready = grant;
  assign busy      = (state != S_IDLE);
  assign cur_valid = |(req_valid & grant);
  assign is_digit  = (cur_data >= 8'd48) && (cur_data <= 8'd57);
  assign is_term   = (cur_data == TERM);

  // Round-robin pick: first valid requester at or after ptr, wrapping modulo N
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!pick_any && ((req_valid >> cand) & N'(1)) != '0) begin
        pick_any = 1'b1;
        pick_idx = ID_W'(cand);
      end
    end
  end

  // Character of the granted requester
  always_comb begin
    cur_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) cur_data = req_data[8*i +: 8];
    end
  end

  // Frame FSM, checker and registered verdict
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      res_valid <= 1'b0;
      res_ok    <= 1'b0;
      res_id    <= '0;
      ptr       <= '0;
      win       <= '0;
      chk_st    <= CHK_START;
      bad       <= 1'b0;
      len       <= '0;
`ifdef EXPR_TIMEOUT_EN
      stall     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            grant  <= N'(1) << pick_idx;
            win    <= pick_idx;
            chk_st <= CHK_START;
            bad    <= 1'b0;
            len    <= '0;
`ifdef EXPR_TIMEOUT_EN
            stall  <= '0;
`endif
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cur_valid) begin
`ifdef EXPR_TIMEOUT_EN
            stall <= '0;
`endif
            if (is_term) begin
              grant     <= '0;
              res_valid <= 1'b1;
              res_ok    <= !bad && (chk_st == CHK_NUM) && (len <= CNT_W'(MAX_LEN));
              res_id    <= win;
              state     <= S_REPORT;
            end else begin
              if (len != CNT_W'(MAX_LEN + 1)) len <= len + CNT_W'(1);
              unique case (chk_st)
                CHK_START: if (is_digit) chk_st <= CHK_NUM; else bad <= 1'b1;
                CHK_NUM:   if (is_digit) bad <= 1'b1;       else chk_st <= CHK_OP;
                CHK_OP:    if (is_digit) chk_st <= CHK_NUM; else bad <= 1'b1;
                default:   bad <= 1'b1;
              endcase
            end
          end
`ifdef EXPR_TIMEOUT_EN
          else if (stall == CNT_W'(TIMEOUT - 1)) begin
            grant     <= '0;
            res_valid <= 1'b1;
            res_ok    <= 1'b0;
            res_id    <= win;
            state     <= S_REPORT;
          end else begin
            stall <= stall + CNT_W'(1);
          end
`endif
        end
        S_REPORT: begin
          res_valid <= 1'b0;
          ptr       <= (win == ID_W'(N - 1)) ? '0 : win + ID_W'(1);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_stream_arb.sv
// Directed bench for expr_stream_arb (N=2): vector table plus hand sequences
// for reset-abort and stall behaviour (EXPR_TIMEOUT_EN aware).
module tb_expr_stream_arb;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        res_valid;
  logic        res_ok;
  logic [0:0]  res_id;

  always #5 clk = ~clk;

  expr_stream_arb #(
    .N(2), .ID_W(1), .TERM(8'd59), .MAX_LEN(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant(grant), .busy(busy),
    .res_valid(res_valid), .res_ok(res_ok), .res_id(res_id)
  );

  typedef struct packed { logic ok; logic [0:0] id; } res_t;
  typedef struct { int r; string s; bit ok; } vec_t;

  int         checks;
  int         errors;
  res_t       res_q[$];
  logic [1:0] grant_q[$];
  vec_t       vq[$];
  string      stream[2];
  int         pos[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int r, input string s, input bit ok);
    vec_t v;
    v.r = r; v.s = s; v.ok = ok;
    vq.push_back(v);
  endtask

  // Streams s0/s1 char by char on req0/req1, logging verdicts and new grants.
  // Entered and left at posedge+1.
  task automatic run(input string s0, input string s1, input int budget);
    int c;
    bit acc[2];
    bit term_acc;
    logic [1:0] prev_g;
    res_t r;
    stream[0] = s0; stream[1] = s1;
    pos[0] = 0; pos[1] = 0;
    res_q.delete(); grant_q.delete();
    c = 0;
    prev_g = grant;
    while (!(pos[0] >= stream[0].len() && pos[1] >= stream[1].len() && !busy)) begin
      if (c >= budget) begin
        chk("run_budget", 32'(c), 32'(budget + 1));
        break;
      end
      term_acc = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (pos[i] < stream[i].len()) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = stream[i][pos[i]];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
      for (int i = 0; i < 2; i++) begin
        acc[i] = req_valid[i] && req_ready[i];
        if (acc[i] && req_data[8*i +: 8] == 8'd59) term_acc = 1'b1;
      end
      @(posedge clk); #1;
      c++;
      for (int i = 0; i < 2; i++) if (acc[i]) pos[i]++;
      if (term_acc) chk("verdict_latency", 32'(res_valid), 1);
      if (res_valid) begin
        r.ok = res_ok; r.id = res_id;
        res_q.push_back(r);
      end
      if (grant != 2'b00 && prev_g == 2'b00) grant_q.push_back(grant);
      prev_g = grant;
    end
    req_valid = 2'b00;
    req_data  = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  found;
    int  seen;
    checks = 0; errors = 0;
    clr_n = 1'b0; req_valid = 2'b00; req_data = 16'h0000;
    #2;
    chk("rst_grant",     32'(grant), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_ok",    32'(res_ok), 0);
    chk("rst_res_id",    32'(res_id), 0);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters continuously valid: grants must alternate starting at req0
    run("1*2;1*2;", "1*2;1*2;", 200);
    chk("rr_res_count", 32'(res_q.size()), 4);
    chk("rr_grant_count", 32'(grant_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < res_q.size()) begin
        chk("rr_res_ok", 32'(res_q[i].ok), 1);
        chk("rr_res_id", 32'(res_q[i].id), 32'(i % 2));
      end
      if (i < grant_q.size()) chk("rr_grant", 32'(grant_q[i]), (i % 2 == 1) ? 2 : 1);
    end

    // Single-frame vector table
    add_vec(0, "1+2;", 1'b1);
    add_vec(0, "12;", 1'b0);
    add_vec(1, ";", 1'b0);
    add_vec(0, "1+;", 1'b0);
    add_vec(1, "+1;", 1'b0);
    add_vec(0, "7;", 1'b1);
    add_vec(1, "1+1+1+1+1+1+1+1+1;", 1'b0);
    add_vec(0, "1+1+1+1+1+1+1+1;", 1'b1);
    add_vec(1, "9-0/3;", 1'b1);
    add_vec(0, "1++2;", 1'b0);
    foreach (vq[v]) begin
      if (vq[v].r == 0) run(vq[v].s, "", 100);
      else              run("", vq[v].s, 100);
      chk({"vec_res_count ", vq[v].s}, 32'(res_q.size()), 1);
      if (res_q.size() > 0) begin
        chk({"vec_res_ok ", vq[v].s}, 32'(res_q[0].ok), 32'(vq[v].ok));
        chk({"vec_res_id ", vq[v].s}, 32'(res_q[0].id), 32'(vq[v].r));
      end
      chk({"vec_grant_count ", vq[v].s}, 32'(grant_q.size()), 1);
      if (grant_q.size() > 0) chk({"vec_grant ", vq[v].s}, 32'(grant_q[0]), 32'(1 << vq[v].r));
      @(posedge clk); #1;
      chk({"vec_res_hold ", vq[v].s}, 32'({res_valid, res_ok}), 32'({1'b0, vq[v].ok}));
    end

    // Reset in the middle of req1's frame drops it with no verdict
    req_valid = 2'b10;
    req_data  = {8'd49, 8'h00};
    found = 1'b0;
    for (k = 0; k < 10; k++) begin
      if (req_ready[1]) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("rst_mid_grant_wait", 32'(found), 1);
    @(posedge clk); #1;
    req_data = {8'd43, 8'h00};
    @(posedge clk); #1;
    req_data = {8'd50, 8'h00};
    chk("rst_mid_busy_before", 32'(busy), 1);
    #2 clr_n = 1'b0;
    #1;
    chk("rst_mid_grant", 32'(grant), 0);
    chk("rst_mid_busy",  32'(busy), 0);
    chk("rst_mid_ready", 32'(req_ready), 0);
    req_valid = 2'b00;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    chk("rst_mid_no_verdict", 32'(seen), 0);
    clr_n = 1'b1;
    run("4;", "5;", 100);
    chk("post_rst_res_count", 32'(res_q.size()), 2);
    if (res_q.size() == 2) begin
      chk("post_rst_first_id",  32'(res_q[0].id), 0);
      chk("post_rst_second_id", 32'(res_q[1].id), 1);
      chk("post_rst_ok", 32'({res_q[0].ok, res_q[1].ok}), 32'(2'b11));
    end
    if (grant_q.size() > 0) chk("post_rst_first_grant", 32'(grant_q[0]), 1);

`ifdef EXPR_TIMEOUT_EN
    // req0 stalls after '1'; frame aborts, then pending req1 is served
    run("1", "3;", 100);
    chk("timeout_res_count", 32'(res_q.size()), 2);
    if (res_q.size() == 2) begin
      chk("timeout_res_ok", 32'(res_q[0].ok), 0);
      chk("timeout_res_id", 32'(res_q[0].id), 0);
      chk("timeout_next_id", 32'(res_q[1].id), 1);
      chk("timeout_next_ok", 32'(res_q[1].ok), 1);
    end
    chk("timeout_grant_count", 32'(grant_q.size()), 2);
    if (grant_q.size() == 2) chk("timeout_next_grant", 32'(grant_q[1]), 2);
`else
    // Without the abort feature a stalled owner keeps the grant forever
    req_valid = 2'b11;
    req_data  = {8'd51, 8'd49};
    found = 1'b0;
    for (k = 0; k < 10; k++) begin
      if (req_ready[0]) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("hold_grant_wait", 32'(found), 1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    chk("hold_no_verdict", 32'(seen), 0);
    chk("hold_grant", 32'(grant), 1);
    chk("hold_busy",  32'(busy), 1);
    req_valid = 2'b00;
    clr_n = 1'b0;
    #1 clr_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
